// File: rtl/serializer_10bit_if.sv
// ---------------------------------------------------------------------------
// serializer_10bit_if
// Bundle of the word handshake and serial link signals of serializer_10bit.
//   in_data     word offered by upstream (master -> slave)
//   in_valid    upstream has a word (master -> slave)
//   in_ready    serializer can take a word (slave -> master)
//   abort       cancel the frame in progress (master -> slave)
//   ser_out     serial data bit, 0 when ser_valid = 0 (slave -> master)
//   ser_valid   ser_out carries a frame bit (slave -> master)
//   frame_start one-cycle pulse on the first cycle of bit 0 (slave -> master)
//   frame_end   one-cycle pulse on the last cycle of the last bit
//   busy        frame in progress, same as ser_valid
// The serializer connects through the slave modport; the word source and
// serial sink use the master modport.
// ---------------------------------------------------------------------------
interface serializer_10bit_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, ser_out, ser_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, ser_out, ser_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/serializer_10bit.sv
// ---------------------------------------------------------------------------
// serializer_10bit
// Parallel-to-serial transmitter. One WIDTH-bit word is accepted on an
// in_valid & in_ready edge and shifted out on ser_out, each bit held for
// BIT_CYCLES clocks, first bit on the cycle after the accept.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  serializer_10bit_if.slave: word handshake, abort, serial outputs
// All outputs except in_ready are registered.
// ---------------------------------------------------------------------------
module serializer_10bit #(
  parameter int WIDTH      = 10,
  parameter int BIT_CYCLES = 1,
  parameter int MSB_FIRST  = 1
) (
  input logic               clk,
  input logic               rst,
  serializer_10bit_if.slave bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [CW-1:0]    cyc_cnt_q;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             frame_start_q;
  logic             frame_end_q;

  logic in_ready;
  logic cyc_last;
  logic bit_last;

  // Bit that goes on the wire next, taken from the head of the word.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its head bit consumed, so the following bit sits at the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign in_ready = (state_q == IDLE) && !rst;
  assign cyc_last = (cyc_cnt_q == CW'(BIT_CYCLES - 1));
  assign bit_last = (bit_cnt_q == BW'(WIDTH - 1));

  // NOTE: every register below is assigned with <= so all branches see the
  // pre-edge values of the counters and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      // NOTE: the shift register is a plain data register but is still
      // cleared so no stale word can leak onto the link after a reset.
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      cyc_cnt_q     <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Abort is ignored here; only the handshake matters.
          if (bus.in_valid && in_ready) begin
            state_q       <= SHIFT;
            shift_q       <= advance(bus.in_data);
            bit_cnt_q     <= '0;
            cyc_cnt_q     <= '0;
            ser_out_q     <= head_bit(bus.in_data);
            ser_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
            frame_end_q   <= 1'b0;  // WIDTH >= 2: bit 0 is never the last bit
          end
        end

        SHIFT: begin
          frame_start_q <= 1'b0;
          if (bus.abort) begin
            // Cancelled frame: drop straight to idle without a frame_end.
            state_q     <= IDLE;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
          end else if (cyc_last) begin
            cyc_cnt_q <= '0;
            if (bit_last) begin
              state_q     <= IDLE;
              ser_out_q   <= 1'b0;
              ser_valid_q <= 1'b0;
              frame_end_q <= 1'b0;
            end else begin
              bit_cnt_q   <= bit_cnt_q + BW'(1);
              ser_out_q   <= head_bit(shift_q);
              shift_q     <= advance(shift_q);
              // Entering the last bit with one-cycle bits: that cycle is the end.
              frame_end_q <= (bit_cnt_q + BW'(1) == BW'(WIDTH - 1)) && (BIT_CYCLES == 1);
            end
          end else begin
            cyc_cnt_q   <= cyc_cnt_q + CW'(1);
            // frame_end is raised one edge early so it is a registered pulse.
            frame_end_q <= bit_last && (cyc_cnt_q + CW'(1) == CW'(BIT_CYCLES - 1));
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.ser_out     = ser_out_q;
  assign bus.ser_valid   = ser_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.busy        = ser_valid_q;

endmodule

// File: tb/tb_serializer_10bit.sv
// ---------------------------------------------------------------------------
// tb_serializer_10bit
// Three serializers share one stimulus stream:
//   inst 0: BIT_CYCLES=1, MSB first
//   inst 1: BIT_CYCLES=3, MSB first
//   inst 2: BIT_CYCLES=1, LSB first
// A reference model keeps, per instance, a queue of the beats the link
// still owes (one entry per clock of ser_valid) and predicts every output
// each cycle. Directed vectors check whole frames against fixed streams.
// ---------------------------------------------------------------------------
module tb_serializer_10bit;

  localparam int BC  [3] = '{1, 3, 1};
  localparam int MSB [3] = '{1, 1, 0};

  typedef struct packed {
    logic b;
    logic s;
    logic e;
  } beat_t;

  typedef struct {
    logic [9:0] data;
    logic [9:0] msb_stream;  // wire order, first bit in [9]
    logic [9:0] lsb_stream;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [9:0] tb_in_data;
  logic       tb_in_valid;
  logic       tb_abort;
  logic       chk_en;

  int n_vec;
  int n_err;
  int cyc;

  beat_t      exp_q    [3][$];
  int         acc_cnt  [3];
  logic       bits_q   [3][$];
  logic [10:0] got_q   [3][$];
  int         starts_q [3][$];
  logic [5:0] obs      [3];

  serializer_10bit_if #(.WIDTH(10)) if_a ();
  serializer_10bit_if #(.WIDTH(10)) if_b ();
  serializer_10bit_if #(.WIDTH(10)) if_c ();

  assign if_a.in_data  = tb_in_data;
  assign if_a.in_valid = tb_in_valid;
  assign if_a.abort    = tb_abort;
  assign if_b.in_data  = tb_in_data;
  assign if_b.in_valid = tb_in_valid;
  assign if_b.abort    = tb_abort;
  assign if_c.in_data  = tb_in_data;
  assign if_c.in_valid = tb_in_valid;
  assign if_c.abort    = tb_abort;

  serializer_10bit #(.WIDTH(10), .BIT_CYCLES(1), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  serializer_10bit #(.WIDTH(10), .BIT_CYCLES(3), .MSB_FIRST(1)) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  serializer_10bit #(.WIDTH(10), .BIT_CYCLES(1), .MSB_FIRST(0)) u_dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave));

  assign obs[0] = {if_a.in_ready, if_a.ser_valid, if_a.ser_out, if_a.frame_start, if_a.frame_end, if_a.busy};
  assign obs[1] = {if_b.in_ready, if_b.ser_valid, if_b.ser_out, if_b.frame_start, if_b.frame_end, if_b.busy};
  assign obs[2] = {if_c.in_ready, if_c.ser_valid, if_c.ser_out, if_c.frame_start, if_c.frame_end, if_c.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Whole frame queued at accept: WIDTH bits, each repeated BIT_CYCLES times.
  task automatic push_frame(input int i, input logic [9:0] w);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < BC[i]; c++) begin
        beat_t bt;
        bt.b = (MSB[i] != 0) ? w[9-k] : w[k];
        bt.s = (k == 0) && (c == 0);
        bt.e = (k == 9) && (c == BC[i] - 1);
        exp_q[i].push_back(bt);
      end
    end
    acc_cnt[i]++;
  endtask

  // Reference model: idle when nothing is owed, otherwise consume one beat.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) exp_q[i].delete();
      else if (exp_q[i].size() != 0) begin
        if (tb_abort) exp_q[i].delete();
        else void'(exp_q[i].pop_front());
      end else if (tb_in_valid) begin
        push_frame(i, tb_in_data);
      end
    end
  end

  // Collected bits of one frame -> stream word; bit 10 flags a bad frame.
  function automatic logic [10:0] assemble(input int i);
    logic [10:0] w = '0;
    int bc = BC[i];
    if (bits_q[i].size() != 10 * bc) return 11'h7FF;
    for (int k = 0; k < 10; k++) begin
      w[9-k] = bits_q[i][k*bc];
      for (int c = 1; c < bc; c++)
        if (bits_q[i][k*bc+c] !== bits_q[i][k*bc]) w[10] = 1'b1;
    end
    return w;
  endfunction

  // Per-cycle output check and frame collector, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [5:0] e;
        if (exp_q[i].size() != 0)
          e = {1'b0, 1'b1, exp_q[i][0].b, exp_q[i][0].s, exp_q[i][0].e, 1'b1};
        else
          e = {~rst, 5'b0};
        check($sformatf("out%0d@%0d", i, cyc), {26'd0, obs[i]}, {26'd0, e});
        if (obs[i][4] === 1'b1) begin
          if (obs[i][2] === 1'b1) begin
            bits_q[i].delete();
            starts_q[i].push_back(cyc);
          end
          bits_q[i].push_back(obs[i][3]);
          if (obs[i][1] === 1'b1) got_q[i].push_back(assemble(i));
        end
      end
    end
  end

  task automatic clear_got();
    for (int i = 0; i < 3; i++) begin
      got_q[i].delete();
      starts_q[i].delete();
    end
  endtask

  function automatic logic [10:0] one_frame(input int i);
    return (got_q[i].size() == 1) ? got_q[i][0] : 11'h7FF;
  endfunction

  task automatic send(input logic [9:0] w);
    tb_in_data  = w;
    tb_in_valid = 1'b1;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_timeout"}, {31'd0, n < 500}, 32'd1);
  endtask

  vec_t vec [6];

  initial begin
    int base;
    vec[0] = '{10'h2A5, 10'h2A5, 10'h295};
    vec[1] = '{10'h3FF, 10'h3FF, 10'h3FF};
    vec[2] = '{10'h200, 10'h200, 10'h001};
    vec[3] = '{10'h001, 10'h001, 10'h200};
    vec[4] = '{10'h155, 10'h155, 10'h2AA};
    vec[5] = '{10'h3C0, 10'h3C0, 10'h00F};

    n_vec = 0; n_err = 0; cyc = 0; chk_en = 1'b0;
    for (int i = 0; i < 3; i++) acc_cnt[i] = 0;
    rst = 1'b1; tb_in_data = '0; tb_in_valid = 1'b0; tb_abort = 1'b0;

    // Reset: outputs cleared, in_ready low while rst is high.
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("reset_ready", {31'd0, if_a.in_ready}, 32'd0);
    check("reset_valid", {31'd0, if_b.ser_valid}, 32'd0);
    rst = 1'b0;
    #1 check("ready_after_reset", {31'd0, if_a.in_ready}, 32'd1);

    // Table-driven whole frames.
    for (int v = 0; v < 6; v++) begin
      clear_got();
      send(vec[v].data);
      wait_idle("vec");
      check($sformatf("vec%0d_inst0", v), {21'd0, one_frame(0)}, {21'd0, 1'b0, vec[v].msb_stream});
      check($sformatf("vec%0d_inst1", v), {21'd0, one_frame(1)}, {21'd0, 1'b0, vec[v].msb_stream});
      check($sformatf("vec%0d_inst2", v), {21'd0, one_frame(2)}, {21'd0, 1'b0, vec[v].lsb_stream});
    end

    // Input changes while shifting do not disturb the captured word.
    clear_got();
    send(10'h155);
    for (int j = 0; j < 9; j++) begin
      tb_in_data  = 10'($urandom);
      tb_in_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    tb_in_valid = 1'b0;
    wait_idle("busy_wr");
    check("busy_wr_inst0", {21'd0, one_frame(0)}, {21'd0, 11'h155});
    check("busy_wr_inst2", {21'd0, one_frame(2)}, {21'd0, 11'h2AA});

    // Abort during bit 4.
    clear_got();
    send(10'h2A5);
    repeat (4) begin @(posedge clk); #1; end
    tb_abort = 1'b1;
    @(posedge clk); #1;
    tb_abort = 1'b0;
    check("abort_valid", {31'd0, if_a.ser_valid}, 32'd0);
    check("abort_ready", {31'd0, if_a.in_ready}, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    check("abort_no_end", got_q[0].size(), 32'd0);

    // Reset during bit 4, then a clean frame.
    clear_got();
    send(10'h2A5);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_valid", {31'd0, if_a.ser_valid}, 32'd0);
    #1 check("rst_ready", {31'd0, if_a.in_ready}, 32'd1);
    check("rst_no_end", got_q[0].size(), 32'd0);
    send(10'h3C0);
    wait_idle("rst_resend");
    check("rst_resend_inst0", {21'd0, one_frame(0)}, {21'd0, 11'h3C0});
    check("rst_resend_inst2", {21'd0, one_frame(2)}, {21'd0, 11'h00F});

    // Back-to-back: in_valid held, word advances on each accept of inst 0.
    clear_got();
    tb_in_data  = 10'd0;
    tb_in_valid = 1'b1;
    base = acc_cnt[0];
    for (int n = 0; n < 1000 && tb_in_valid; n++) begin
      @(posedge clk); #1;
      if (acc_cnt[0] != base) begin
        base = acc_cnt[0];
        if (tb_in_data == 10'd62) tb_in_valid = 1'b0;
        else tb_in_data = tb_in_data + 10'd1;
      end
    end
    check("b2b_done", {31'd0, tb_in_valid}, 32'd0);
    wait_idle("b2b");
    check("b2b_count", got_q[0].size(), 32'd63);
    for (int j = 0; j < got_q[0].size(); j++)
      check($sformatf("b2b_word%0d", j), {21'd0, got_q[0][j]}, j);
    for (int j = 1; j < starts_q[0].size(); j++)
      check($sformatf("b2b_gap%0d", j), starts_q[0][j] - starts_q[0][j-1], 32'd11);

    // Random traffic with occasional abort and reset.
    for (int n = 0; n < 3000; n++) begin
      tb_in_data  = 10'($urandom);
      tb_in_valid = 1'($urandom);
      tb_abort    = ($urandom_range(0, 39) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    tb_in_valid = 1'b0;
    tb_abort    = 1'b0;
    rst         = 1'b0;
    wait_idle("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
